uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised successor of the team's 8-bit UART transmitter, built for the host link of the matrix-multiply engine. Runs on the system clock with an internal baud divider rather than a baud-rate clock. It has:
- a valid/ready input handshake;
- a configurable frame: data width, optional even/odd parity, 1 or 2 stop bits.

It sits between the result-streaming logic and the FPGA TX pin.

Parameters:
- CLK_DIV, 868, system clocks per bit period (100 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; value 3 is illegal and gives an elaboration error.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; low freezes the block in place.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  DATA_BITS  word to send, sent LSB first.
- in_ready  out  1  block can accept a word this cycle.
- out  out  1  serial TX line; idle high.
- busy  out  1  a frame is in progress (START_BIT through the last stop bit).
- done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values, applied on the clk edge with rst=1, from any state: out=1, in_ready=0, busy=0, done=0, state=IDLE, baud counter=0, bit index=0, data register=0. Reset mid-frame aborts the frame; the line is high from the next cycle and no done pulse is produced.
- in_ready = (state==IDLE) && en && !rst, registered. A transfer occurs on a cycle with in_valid && in_ready. in_data is latched only on a transfer and never sampled otherwise.
- Parity is computed from the latched word at transfer time: even → ^data, odd → ~^data.
- State machine (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT):
  - IDLE: out=1, busy=0. On transfer → START_BIT; busy=1 and in_ready=0 from the next cycle.
  - START_BIT: out=0 for CLK_DIV cycles → DATA_BITS.
  - DATA_BITS: out=data[idx] for CLK_DIV cycles per bit, idx from 0 to DATA_BITS-1. After the last bit → PARITY_BIT if PARITY_MODE≠0, else → STOP_BIT.
  - PARITY_BIT: out=parity for CLK_DIV cycles → STOP_BIT.
  - STOP_BIT: out=1 for STOP_BITS*CLK_DIV cycles. On the final cycle: done=1 for exactly one cycle, busy=0, → IDLE.
- Latency and frame length:
  - The first start-bit cycle on out is the cycle after the transfer cycle.
  - Frame length is (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) * CLK_DIV cycles.
  - in_ready reasserts in the cycle after done. Back-to-back frames are therefore separated by exactly 1 idle-high cycle (when in_valid is held high).
- Baud counter:
  - Counts 0..CLK_DIV-1; width $clog2(CLK_DIV).
  - A bit tick occurs at terminal count and the counter wraps to 0.
  - Cleared on entry to START_BIT, so bit periods are always exactly CLK_DIV cycles.
- en low:
  - The baud counter, bit index and state hold; out holds its current level.
  - in_ready=0 and done is not asserted.
  - Resuming continues the current bit with the remaining count.
- Simultaneous events: rst has priority over everything. A done/transfer overlap is impossible because in_ready=0 whenever done=1.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (3-bit localparams, shared with the receiver);
  - PARITY_NONE/EVEN/ODD constants;
  - a function computing the parity bit from data and mode.
- Sub-module uart_baud_gen: parametrised CLK_DIV counter with clear and en, producing a one-cycle tick. It is reused by the future receiver, there configured at 16x oversample.

Test Plan:
1. CLK_DIV=4, DATA_BITS=8, no parity, 1 stop. Send 0xA5 → out: 4×0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4×1. done pulses on cycle 40 after the transfer; busy high for those 40 cycles.
2. PARITY_MODE=1, send 0x07 → parity bit 1. PARITY_MODE=2, send 0x07 → parity bit 0. Frame is 44 cycles at CLK_DIV=4.
3. STOP_BITS=2, DATA_BITS=5, send 0x1F → stop high for 8 cycles, 32-cycle frame, one done pulse.
4. Hold in_valid high with 0x11 then 0x22 → two frames, exactly one idle-high cycle between them, two done pulses; in_ready low during each frame.
5. Assert rst at cycle 15 of a frame → out=1 next cycle; busy, done and in_ready low; no done pulse. A new transfer after reset sends a clean frame.
6. Deassert en for 10 cycles mid data bit 3 → out holds bit 3, and the bit lasts CLK_DIV+10 cycles in total. in_valid=1 during IDLE with en=0 → no transfer.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and parity helper shared by the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  // Unused upper bits must be zero; they then leave the reduction unchanged.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: CLK_DIV cycle counter with clear/enable producing a one-cycle tick at terminal count
module uart_baud_gen #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = en && !clear && (cnt == CW'(CLK_DIV - 1));
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready input and internal baud divider
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = $clog2(DATA_BITS);
  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_param: illegal parameter combination");
  end
  uart_state_e state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] data, data_n;
  logic par, par_n, line_n, tick, rdy_q, xfer;
  assign in_ready = rdy_q && en && !rst;
  assign xfer = in_valid && in_ready;
  // Holding the counter clear while idle makes every start bit a full period.
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clear(state == S_IDLE),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    data_n = data;
    par_n = par;
    done = 1'b0;
    unique case (state)
      S_IDLE: if (xfer) begin
        state_n = S_START;
        data_n = in_data;
        par_n = parity_bit(9'(in_data), PARITY_MODE);
      end
      S_START: if (tick) state_n = S_DATA;
      S_DATA: if (tick) begin
        idx_n = (idx == IW'(DATA_BITS - 1)) ? '0 : idx + IW'(1);
        if (idx == IW'(DATA_BITS - 1)) state_n = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (tick) state_n = S_STOP;
      S_STOP: if (tick) begin
        idx_n = (idx == IW'(STOP_BITS - 1)) ? '0 : idx + IW'(1);
        if (idx == IW'(STOP_BITS - 1)) begin
          state_n = S_IDLE;
          done = !rst;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // The line is registered from the next state so the pin never glitches.
    line_n = (state_n == S_START) ? 1'b0 :
             (state_n == S_DATA) ? data_n[idx_n] :
             (state_n == S_PARITY) ? par_n : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      data <= '0;
      par <= 1'b0;
      out <= 1'b1;
      busy <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      data <= data_n;
      par <= par_n;
      out <= line_n;
      busy <= (state_n != S_IDLE);
      rdy_q <= (state_n == S_IDLE);
    end
  end
endmodule
